// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 Set-2 scan-code sequencer with repeat filter and event FIFO
module ps2_kbd_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 2000000,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_brk,
    output logic             evt_rpt,
    output logic             key_down,
    output logic [CNT_W-1:0] press_cnt,
    output logic             busy,
    output logic             err,
    output logic             ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t           state;
    state_t           nxt;
    logic [TW-1:0]    tcnt;
    logic             timeout;

    logic             is_e0;
    logic             is_f0;
    logic             is_pfx;
    logic             is_drop;

    logic             ev_push;
    logic             ev_ext;
    logic             ev_brk;
    logic             ev_rpt;
    logic             err_set;
    logic             held_match;

    logic             held_vld;
    logic [7:0]       held_code;
    logic             held_ext;

    logic [10:0]      mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic [10:0]      head;

    assign is_e0   = (byte_data == 8'hE0);
    assign is_f0   = (byte_data == 8'hF0);
    assign is_pfx  = is_e0 || is_f0;
    assign is_drop = (byte_data == 8'h00) || (byte_data == 8'hAA) || (byte_data == 8'hEE) ||
                     (byte_data == 8'hFA) || (byte_data == 8'hFC) || (byte_data == 8'hFE) ||
                     (byte_data == 8'hFF);

    // A prefix left dangling too long is abandoned; a byte arriving on the same cycle wins
    assign timeout = (state != IDLE) && !byte_valid && (tcnt == T_MAX);

    // State register
    always_ff @(posedge clk) begin
        if (!clrn) state <= IDLE;
        else       state <= nxt;
    end

    // Next-state decode of the prefix sequence
    always_comb begin
        nxt = state;
        if (timeout) begin
            nxt = IDLE;
        end else if (byte_valid) begin
            case (state)
                IDLE:    if (is_e0) nxt = EXT;
                         else if (is_f0) nxt = BRK;
                EXT:     if (is_f0) nxt = EXT_BRK;
                         else if (!is_e0) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    // Event and error generation for the byte being accepted
    always_comb begin
        ev_push = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        err_set = 1'b0;
        if (timeout) begin
            err_set = 1'b1;
        end else if (byte_valid) begin
            case (state)
                IDLE: ev_push = !is_pfx && !is_drop;
                EXT: begin
                    ev_push = !is_pfx;
                    ev_ext  = 1'b1;
                end
                BRK: begin
                    ev_push = !is_pfx;
                    ev_brk  = 1'b1;
                    err_set = is_pfx;
                end
                default: begin
                    ev_push = !is_pfx;
                    ev_brk  = 1'b1;
                    ev_ext  = 1'b1;
                    err_set = is_pfx;
                end
            endcase
        end
    end

    assign held_match = held_vld && (held_code == byte_data) && (held_ext == ev_ext);
    assign ev_rpt     = ev_push && !ev_brk && held_match;

    // Prefix wait counter, only runs while a prefix is pending
    always_ff @(posedge clk) begin
        if (!clrn || byte_valid || state == IDLE) tcnt <= '0;
        else                                      tcnt <= tcnt + TW'(1);
    end

    // Held-key tracking and distinct press counting (independent of FIFO space)
    always_ff @(posedge clk) begin
        if (!clrn) begin
            held_vld  <= 1'b0;
            held_code <= 8'h00;
            held_ext  <= 1'b0;
            press_cnt <= '0;
        end else if (ev_push) begin
            if (!ev_brk && !held_match) begin
                held_vld  <= 1'b1;
                held_code <= byte_data;
                held_ext  <= ev_ext;
                press_cnt <= press_cnt + CNT_W'(1);
            end else if (ev_brk && held_match) begin
                held_vld <= 1'b0;
            end
        end
    end

    // Sticky protocol and overflow flags
    always_ff @(posedge clk) begin
        if (!clrn) begin
            err <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (err_set) err <= 1'b1;
            if (ev_push && full && !pop) ovf <= 1'b1;
        end
    end

    assign full    = (cnt == FULL_CNT);
    assign pop     = (cnt != '0) && evt_ready;
    assign push_ok = ev_push && (!full || pop);

    // Event storage, unreset: the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= {ev_rpt, ev_brk, ev_ext, byte_data};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!clrn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop)     rptr <= rptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + (AW + 1)'(1);
                2'b01:   cnt <= cnt - (AW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head      = evt_valid ? mem[rptr] : 11'h000;
    assign evt_valid = (cnt != '0);
    assign evt_rpt   = head[10];
    assign evt_brk   = head[9];
    assign evt_ext   = head[8];
    assign evt_code  = head[7:0];
    assign key_down  = held_vld;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - directed self-checking bench for ps2_kbd_ctrl
module tb_ps2_kbd_ctrl;

    logic       clk = 1'b0;
    logic       clrn;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       evt_ready;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic       evt_rpt;
    logic       key_down;
    logic [7:0] press_cnt;
    logic       busy;
    logic       err;
    logic       ovf;

    int n_cmp = 0;
    int n_bad = 0;

    ps2_kbd_ctrl #(.DEPTH(4), .TIMEOUT(16), .CNT_W(8)) dut (
        .clk(clk), .clrn(clrn), .byte_valid(byte_valid), .byte_data(byte_data),
        .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_code(evt_code),
        .evt_ext(evt_ext), .evt_brk(evt_brk), .evt_rpt(evt_rpt), .key_down(key_down),
        .press_cnt(press_cnt), .busy(busy), .err(err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // {valid, rpt, brk, ext, code}
    function automatic logic [11:0] ev();
        return {evt_valid, evt_rpt, evt_brk, evt_ext, evt_code};
    endfunction

    // {key_down, busy, err, ovf, press_cnt}
    function automatic logic [11:0] st();
        return {key_down, busy, err, ovf, press_cnt};
    endfunction

    task automatic do_reset();
        clrn = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; evt_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1; byte_data = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({ev(), st()} !== 24'h0) begin
            n_bad++; $display("FAIL reset: got ev=%h st=%h want 0/0", ev(), st());
        end
    endtask

    task automatic test_make_break();
        logic [11:0] e [3];
        logic [11:0] s [3];
        logic [7:0]  b [3];
        b = '{8'h1C, 8'hF0, 8'h1C};
        e = '{{4'b1000, 8'h1C}, 12'h000, {4'b1010, 8'h1C}};
        s = '{{4'b1000, 8'd1}, {4'b1100, 8'd1}, {4'b0000, 8'd1}};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(b[i]);
            n_cmp++;
            if (ev() !== e[i] || st() !== s[i]) begin
                n_bad++; $display("FAIL make_break[%0d]: got ev=%h st=%h want ev=%h st=%h", i, ev(), st(), e[i], s[i]);
            end
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic test_extended();
        do_reset();
        send(8'hE0); send(8'h75);
        n_cmp++;
        if (ev() !== {4'b1001, 8'h75}) begin
            n_bad++; $display("FAIL ext_make: got %h want %h", ev(), {4'b1001, 8'h75});
        end
        send(8'hE0); send(8'hF0);
        n_cmp++;
        if (busy !== 1'b1 || evt_valid !== 1'b0) begin
            n_bad++; $display("FAIL ext_pending: got busy=%b valid=%b want 1/0", busy, evt_valid);
        end
        send(8'h75);
        n_cmp++;
        if (ev() !== {4'b1011, 8'h75} || st() !== {4'b0000, 8'd1}) begin
            n_bad++; $display("FAIL ext_break: got ev=%h st=%h want %h/%h", ev(), st(), {4'b1011, 8'h75}, {4'b0000, 8'd1});
        end
    endtask

    task automatic test_repeat();
        logic [11:0] e [5];
        logic [7:0]  b [5];
        b = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
        e = '{{4'b1000, 8'h1C}, {4'b1100, 8'h1C}, {4'b1100, 8'h1C}, 12'h000, {4'b1010, 8'h1C}};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(b[i]);
            n_cmp++;
            if (ev() !== e[i] || press_cnt !== 8'd1) begin
                n_bad++; $display("FAIL repeat[%0d]: got ev=%h cnt=%0d want ev=%h cnt=1", i, ev(), press_cnt, e[i]);
            end
        end
    endtask

    task automatic test_discard();
        do_reset();
        send(8'hAA); send(8'hFA); send(8'h00);
        n_cmp++;
        if (evt_valid !== 1'b0 || st() !== 12'h0) begin
            n_bad++; $display("FAIL discard: got valid=%b st=%h want 0/000", evt_valid, st());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b [5];
        b = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(b[i]);
        n_cmp++;
        if (ovf !== 1'b0 || ev() !== {4'b1000, 8'h15}) begin
            n_bad++; $display("FAIL ovf_full: got ovf=%b ev=%h want 0/%h", ovf, ev(), {4'b1000, 8'h15});
        end
        send(b[4]);
        n_cmp++;
        if (st() !== {4'b1001, 8'd5}) begin
            n_bad++; $display("FAIL ovf_set: got st=%h want %h", st(), {4'b1001, 8'd5});
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ev() !== {4'b1000, b[i]}) begin
                n_bad++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, ev(), {4'b1000, b[i]});
            end
            @(negedge clk);
        end
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++; $display("FAIL ovf_empty: got valid=%b want 0", evt_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [5];
        b = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h16};
        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(b[i]);
        evt_ready = 1'b1;
        send(b[4]);
        n_cmp++;
        if (ovf !== 1'b0 || press_cnt !== 8'd5 || ev() !== {4'b1000, 8'h12}) begin
            n_bad++; $display("FAIL full_push_pop: got ovf=%b cnt=%0d ev=%h want 0/5/%h", ovf, press_cnt, ev(), {4'b1000, 8'h12});
        end
        for (int i = 1; i < 5; i++) begin
            n_cmp++;
            if (ev() !== {4'b1000, b[i]}) begin
                n_bad++; $display("FAIL b2b_drain[%0d]: got %h want %h", i, ev(), {4'b1000, b[i]});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send(8'hF0);
        repeat (15) @(negedge clk);
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL timeout_early: got err=%b busy=%b want 0/1", err, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0 || evt_valid !== 1'b0) begin
            n_bad++; $display("FAIL timeout_fire: got err=%b busy=%b valid=%b want 1/0/0", err, busy, evt_valid);
        end
        repeat (4) @(negedge clk);
        send(8'h1C);
        n_cmp++;
        if (ev() !== {4'b1000, 8'h1C} || press_cnt !== 8'd1) begin
            n_bad++; $display("FAIL timeout_after: got ev=%h cnt=%0d want %h/1", ev(), press_cnt, {4'b1000, 8'h1C});
        end
    endtask

    task automatic test_bad_prefix();
        do_reset();
        send(8'hF0); send(8'hE0);
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0 || evt_valid !== 1'b0) begin
            n_bad++; $display("FAIL bad_prefix: got err=%b busy=%b valid=%b want 1/0/0", err, busy, evt_valid);
        end
        send(8'hE0);
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        n_cmp++;
        if ({ev(), st()} !== 24'h0) begin
            n_bad++; $display("FAIL mid_reset: got ev=%h st=%h want 0/0", ev(), st());
        end
        send(8'h75);
        n_cmp++;
        if (ev() !== {4'b1000, 8'h75}) begin
            n_bad++; $display("FAIL post_reset_make: got %h want %h", ev(), {4'b1000, 8'h75});
        end
    endtask

    initial begin
        clrn = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; evt_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_make_break();
        test_extended();
        test_repeat();
        test_discard();
        test_overflow();
        test_back_to_back();
        test_timeout();
        test_bad_prefix();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
